fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the program counter, drives the address of the combinational
//  instruction ROM, and registers each returned word with its PC into an IF/ID output register.
//  The decode stage takes the IF/ID register through a valid/ready handshake.
//  Supports stall (backpressure), branch redirect with flush, and halt at end of program.
// PARAMETERS
//  ADDR_W     3    PC / ROM address width
//  DATA_W     32   instruction width
//  NUM_INSTR  6    number of valid ROM entries (addresses 0..NUM_INSTR-1)
//  RESET_PC   0    PC value after reset
//  WRAP       0    1: PC wraps NUM_INSTR-1 -> 0; 0: halt after last entry
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       synchronous active-low reset
//  imem_addr       out  ADDR_W  ROM address (= pc register, combinational)
//  imem_instr      in   DATA_W  ROM read data, same-cycle combinational return
//  redirect_valid  in   1       branch/jump redirect request, single-cycle pulse
//  redirect_pc     in   ADDR_W  redirect target
//  out_valid       out  1       IF/ID register holds a valid instruction
//  out_ready       in   1       decode accepts out_instr/out_pc this cycle
//  out_instr       out  DATA_W  registered instruction
//  out_pc          out  ADDR_W  PC of out_instr
//  done            out  1       fetch halted (sticky)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pc=RESET_PC, out_valid=0, out_instr=0 (NOP), out_pc=0, done=0,
//    state=FETCH. Reset mid-stream discards the held instruction; there is no partial state.
//  - States: FETCH, HALT. done = (state==HALT), registered.
//  - load = (state==FETCH) && (!out_valid || out_ready). On load: out_instr<=imem_instr,
//    out_pc<=pc, out_valid<=1, pc<=pc+1. Latency: addr to out_valid is 1 cycle; throughput is
//    1 instr/cycle while out_ready=1.
//  - Stall: out_valid && !out_ready holds pc, out_instr, and out_pc stable. out_valid must not drop.
//  - Accept without load (HALT): out_valid && out_ready sets out_valid<=0.
//  - End of program: load with pc==NUM_INSTR-1:
//    WRAP=1 sets pc<=0.
//    WRAP=0 sets pc<=0 and state<=HALT. The last word is still presented and must be accepted.
//  - Redirect (highest priority, beats stall/load/halt): out_valid<=0 (flush), pc<=redirect_pc,
//    state<=FETCH, done<=0. The held instruction is dropped even if out_ready=1 in that cycle.
//    If redirect_pc>=NUM_INSTR, state<=HALT and done<=1 instead.
//  - PC arithmetic: modulo 2^ADDR_W. Entries >= NUM_INSTR are never fetched in FETCH.
//  - imem_addr is always pc. In HALT, pc=0 and no load occurs.
// STRUCTURE
//  - Shared package pipeline_pkg: ADDR_W, DATA_W, NOP_INSTR (32'h0), fetch_state_t {FETCH, HALT}.
//  - Single module. An optional sub-module pc_reg holds pc and next-pc muxing
//    (reset, redirect, increment, wrap).
//  - No FIFO: the IF/ID register is the only buffer.
// TESTING (program ROM: 0->32'h00620000, 1->32'h00640000, 2..5 per program, default NOP)
//  1 Reset then out_ready=1 steady -> out_valid rises 1 cycle after reset release.
//    out_pc runs 0,1,2,3,4,5 and out_instr(0)=32'h00620000, out_instr(1)=32'h00640000.
//    With WRAP=0, done=1 the cycle after pc 5 loads and out_valid=0 after pc 5 is accepted.
//  2 Stall: out_ready=0 for 3 cycles while out_pc=2 -> out_pc, out_instr, and imem_addr=3 held;
//    out_valid stays 1. On release, out_pc=3 follows with no skipped or duplicated PC.
//  3 Redirect: redirect_valid=1, redirect_pc=1 while out_pc=4 valid -> next cycle out_valid=0;
//    the cycle after, out_pc=1 and out_instr=32'h00640000.
//  4 Redirect during stall, and redirect in HALT with pc=0 -> redirect wins.
//    Flush occurs and done clears; fetch resumes from 0.
//  5 redirect_pc=7 (>=NUM_INSTR) -> done=1, out_valid=0, and no further loads.
//  6 WRAP=1 -> out_pc runs ...4,5,0,1 and done stays 0.
//    rst_n=0 mid-stream -> all outputs take reset values at the next edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module  : pipeline_pkg
// Brief   : Shared widths, NOP encoding and fetch FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module  : fetch_stage_if
// Brief   : IF/ID register handshake between fetch (master) and decode (slave).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if;
    import pipeline_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

`default_nettype wire

// File: rtl/fetch_stage_pc_reg.sv
// ============================================================================
// Module  : pc_reg
// Brief   : Program counter with reset, redirect, increment and end-of-ROM wrap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_reg
    import pipeline_pkg::*;
#(
    parameter int NUM_INSTR = 6,
    parameter int RESET_PC  = 0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              redirect_valid,
    input  wire logic [ADDR_W-1:0] redirect_pc,
    input  wire logic              load,
    output logic      [ADDR_W-1:0] pc,
    output logic                   pc_last,
    output logic                   redirect_oob
);

    // One extra bit so NUM_INSTR == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]   C_NUM  = (ADDR_W+1)'(NUM_INSTR);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(NUM_INSTR - 1);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    assign pc           = pc_q;
    assign pc_last      = (pc_q == C_LAST);
    assign redirect_oob = ({1'b0, redirect_pc} >= C_NUM);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_oob ? '0 : redirect_pc;
        end else if (load) begin
            pc_d = pc_last ? '0 : pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Brief   : Instruction fetch: PC, combinational ROM address, IF/ID register
//           with valid/ready handshake, redirect flush and halt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int NUM_INSTR = 6,
    parameter int RESET_PC  = 0,
    parameter bit WRAP      = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    output logic      [ADDR_W-1:0] imem_addr,
    input  wire logic [DATA_W-1:0] imem_instr,
    input  wire logic              redirect_valid,
    input  wire logic [ADDR_W-1:0] redirect_pc,
    fetch_stage_if.master          out_if,
    output logic                   done
);

    logic [ADDR_W-1:0] pc;
    logic              pc_last;
    logic              redirect_oob;
    logic              load;

    fetch_state_t      state_d,     state_q;
    logic              out_valid_d, out_valid_q;
    logic [DATA_W-1:0] out_instr_d, out_instr_q;
    logic [ADDR_W-1:0] out_pc_d,    out_pc_q;
    logic              done_q;

    pc_reg #(
        .NUM_INSTR (NUM_INSTR),
        .RESET_PC  (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .load           (load),
        .pc             (pc),
        .pc_last        (pc_last),
        .redirect_oob   (redirect_oob)
    );

    assign load = (state_q == FETCH) && (!out_valid_q || out_if.out_ready);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (redirect_valid) begin
            // Flush wins even when decode is accepting this cycle.
            out_valid_d = 1'b0;
            state_d     = redirect_oob ? HALT : FETCH;
        end else if (load) begin
            out_instr_d = imem_instr;
            out_pc_d    = pc;
            out_valid_d = 1'b1;
            if (pc_last && !WRAP) begin
                state_d = HALT;
            end
        end else if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            done_q      <= (state_d == HALT);
        end
    end

    assign imem_addr        = pc;
    assign done             = done_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_instr = out_instr_q;
    assign out_if.out_pc    = out_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Self-checking bench for fetch_stage (WRAP=0 and WRAP=1 instances).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;
    import pipeline_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rdy = 1'b0;
    logic              redir = 1'b0;
    logic [ADDR_W-1:0] rpc = '0;

    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] instr0, instr1;
    logic              done0, done1;
    logic [DATA_W-1:0] rom [8];

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage_if if0 ();
    fetch_stage_if if1 ();

    assign if0.out_ready = rdy;
    assign if1.out_ready = rdy;
    assign instr0 = rom[addr0];
    assign instr1 = rom[addr1];

    always #5 clk = ~clk;

    fetch_stage #(.NUM_INSTR(6), .RESET_PC(0), .WRAP(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr0), .imem_instr(instr0),
        .redirect_valid(redir), .redirect_pc(rpc), .out_if(if0.master), .done(done0)
    );

    fetch_stage #(.NUM_INSTR(6), .RESET_PC(0), .WRAP(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr1), .imem_instr(instr1),
        .redirect_valid(redir), .redirect_pc(rpc), .out_if(if1.master), .done(done1)
    );

    // Reference model: one entry per instance, index 0 = WRAP 0, 1 = WRAP 1.
    int          m_pc    [2];
    bit          m_valid [2];
    logic [31:0] m_instr [2];
    int          m_opc   [2];
    bit          m_halt  [2];
    bit          m_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int w = 0; w < 2; w++) begin
            if (!rst_n) begin
                m_pc[w] = 0; m_valid[w] = 0; m_instr[w] = 0; m_opc[w] = 0; m_halt[w] = 0;
            end else if (redir) begin
                m_valid[w] = 0;
                if (int'(rpc) >= 6) begin
                    m_halt[w] = 1; m_pc[w] = 0;
                end else begin
                    m_halt[w] = 0; m_pc[w] = int'(rpc);
                end
            end else if (!m_halt[w] && (!m_valid[w] || rdy)) begin
                m_instr[w] = rom[m_pc[w]];
                m_opc[w]   = m_pc[w];
                m_valid[w] = 1;
                if (m_pc[w] == 5) begin
                    m_pc[w] = 0;
                    if (w == 0) m_halt[w] = 1;
                end else begin
                    m_pc[w] = m_pc[w] + 1;
                end
            end else if (m_valid[w] && rdy) begin
                m_valid[w] = 0;
            end
        end
        if (!rst_n) m_ok = 1'b1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (m_ok) begin
            chk("m0_valid", 32'(if0.out_valid), 32'(m_valid[0]));
            chk("m0_pc",    32'(if0.out_pc),    32'(m_opc[0]));
            chk("m0_instr", if0.out_instr,      m_instr[0]);
            chk("m0_addr",  32'(addr0),         32'(m_pc[0]));
            chk("m0_done",  32'(done0),         32'(m_halt[0]));
            chk("m1_valid", 32'(if1.out_valid), 32'(m_valid[1]));
            chk("m1_pc",    32'(if1.out_pc),    32'(m_opc[1]));
            chk("m1_instr", if1.out_instr,      m_instr[1]);
            chk("m1_addr",  32'(addr1),         32'(m_pc[1]));
            chk("m1_done",  32'(done1),         32'(m_halt[1]));
        end
    endtask

    typedef struct {
        bit          rst_n;
        bit          rdy;
        bit          redir;
        int          rpc;
        bit          e_valid;
        int          e_pc;
        logic [31:0] e_instr;
        bit          e_done;
        int          e_addr;
    } vec_t;

    vec_t vecs [29];

    initial begin
        rom[0] = 32'h0062_0000; rom[1] = 32'h0064_0000; rom[2] = 32'h0066_0000;
        rom[3] = 32'h0068_0000; rom[4] = 32'h006a_0000; rom[5] = 32'h006c_0000;
        rom[6] = 32'h0000_0000; rom[7] = 32'h0000_0000;

        // Expected values for the WRAP=0 instance after each edge.
        //          rst rdy rdr rpc  val pc  instr          done addr
        vecs[0]  = '{0, 1, 0, 0,   0, 0, 32'h0,          0, 0};
        vecs[1]  = '{1, 1, 0, 0,   1, 0, 32'h0062_0000,  0, 1};
        vecs[2]  = '{1, 1, 0, 0,   1, 1, 32'h0064_0000,  0, 2};
        vecs[3]  = '{1, 1, 0, 0,   1, 2, 32'h0066_0000,  0, 3};
        vecs[4]  = '{1, 0, 0, 0,   1, 2, 32'h0066_0000,  0, 3};
        vecs[5]  = '{1, 0, 0, 0,   1, 2, 32'h0066_0000,  0, 3};
        vecs[6]  = '{1, 0, 0, 0,   1, 2, 32'h0066_0000,  0, 3};
        vecs[7]  = '{1, 1, 0, 0,   1, 3, 32'h0068_0000,  0, 4};
        vecs[8]  = '{1, 1, 0, 0,   1, 4, 32'h006a_0000,  0, 5};
        vecs[9]  = '{1, 1, 1, 1,   0, 4, 32'h006a_0000,  0, 1};
        vecs[10] = '{1, 1, 0, 0,   1, 1, 32'h0064_0000,  0, 2};
        vecs[11] = '{1, 1, 0, 0,   1, 2, 32'h0066_0000,  0, 3};
        vecs[12] = '{1, 1, 0, 0,   1, 3, 32'h0068_0000,  0, 4};
        vecs[13] = '{1, 1, 0, 0,   1, 4, 32'h006a_0000,  0, 5};
        vecs[14] = '{1, 1, 0, 0,   1, 5, 32'h006c_0000,  1, 0};
        vecs[15] = '{1, 0, 0, 0,   1, 5, 32'h006c_0000,  1, 0};
        vecs[16] = '{1, 1, 0, 0,   0, 5, 32'h006c_0000,  1, 0};
        vecs[17] = '{1, 1, 0, 0,   0, 5, 32'h006c_0000,  1, 0};
        vecs[18] = '{1, 1, 1, 0,   0, 5, 32'h006c_0000,  0, 0};
        vecs[19] = '{1, 1, 0, 0,   1, 0, 32'h0062_0000,  0, 1};
        vecs[20] = '{1, 0, 0, 0,   1, 0, 32'h0062_0000,  0, 1};
        vecs[21] = '{1, 0, 1, 3,   0, 0, 32'h0062_0000,  0, 3};
        vecs[22] = '{1, 0, 0, 0,   1, 3, 32'h0068_0000,  0, 4};
        vecs[23] = '{1, 1, 1, 7,   0, 3, 32'h0068_0000,  1, 0};
        vecs[24] = '{1, 1, 0, 0,   0, 3, 32'h0068_0000,  1, 0};
        vecs[25] = '{1, 1, 0, 0,   0, 3, 32'h0068_0000,  1, 0};
        vecs[26] = '{1, 1, 1, 2,   0, 3, 32'h0068_0000,  0, 2};
        vecs[27] = '{1, 1, 0, 0,   1, 2, 32'h0066_0000,  0, 3};
        vecs[28] = '{0, 1, 0, 0,   0, 0, 32'h0,          0, 0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 29; i++) begin
            rst_n = vecs[i].rst_n;
            rdy   = vecs[i].rdy;
            redir = vecs[i].redir;
            rpc   = ADDR_W'(vecs[i].rpc);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(if0.out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_pc", i),    32'(if0.out_pc),    32'(vecs[i].e_pc));
            chk($sformatf("vec%0d_instr", i), if0.out_instr,      vecs[i].e_instr);
            chk($sformatf("vec%0d_done", i),  32'(done0),         32'(vecs[i].e_done));
            chk($sformatf("vec%0d_addr", i),  32'(addr0),         32'(vecs[i].e_addr));
        end

        // WRAP=1 instance runs past the last entry without halting.
        rst_n = 1'b0; rdy = 1'b1; redir = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("wrap%0d_pc", i),    32'(if1.out_pc),    32'(i % 6));
            chk($sformatf("wrap%0d_valid", i), 32'(if1.out_valid), 32'd1);
            chk($sformatf("wrap%0d_done", i),  32'(done1),         32'd0);
            chk($sformatf("wrap%0d_instr", i), if1.out_instr,      rom[i % 6]);
        end

        // Mid-stream reset on the running WRAP=1 instance.
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(if1.out_valid), 32'd0);
        chk("midrst_instr", if1.out_instr,      32'h0);
        chk("midrst_addr",  32'(addr1),         32'd0);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 11) == 0);
            rpc   = ADDR_W'($urandom_range(0, 7));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
